// File: rtl/fp_exp_pkg.sv
// rtl/fp_exp_pkg.sv - shared types and width helpers for the FPU exponent add/sub pipe
package fp_exp_pkg;

    typedef enum logic {
        EXP_MUL = 1'b0,
        EXP_DIV = 1'b1
    } exp_op_t;

    typedef struct packed {
        logic ovf;
        logic unf;
    } exp_flags_t;

    // Largest finite biased exponent; the all-ones code stays reserved for Inf/NaN.
    function automatic int exp_maxe(input int exp_w);
        return (1 << exp_w) - 2;
    endfunction

    // Two guard bits keep the sum of two exponents plus bias/adjust from wrapping.
    function automatic int exp_int_w(input int exp_w);
        return exp_w + 2;
    endfunction

endpackage

// File: rtl/fp_exp_classify.sv
// rtl/fp_exp_classify.sv - saturates a raw signed exponent and flags overflow/underflow
module fp_exp_classify
    import fp_exp_pkg::*;
#(
    parameter int  EXP_W = 8,
    localparam int IW    = exp_int_w(EXP_W)
) (
    input  logic signed [IW-1:0]    r,
    output logic        [EXP_W-1:0] exp_sat,
    output exp_flags_t              flags
);

    localparam logic signed [IW-1:0] MAXE_S = IW'(exp_maxe(EXP_W));
    localparam logic signed [IW-1:0] ONE_S  = IW'(1);

    always_comb begin
        flags   = '0;
        exp_sat = r[EXP_W-1:0];
        if (r > MAXE_S) begin
            flags.ovf = 1'b1;
            exp_sat   = '1;
        end else if (r < ONE_S) begin
            flags.unf = 1'b1;
            exp_sat   = '0;
        end
    end

endmodule

// File: rtl/fp_exp_addsub_pipe.sv
// rtl/fp_exp_addsub_pipe.sv - two-stage exponent combine/saturate pipe; divide path under FP_EXP_DIV_EN
module fp_exp_addsub_pipe
    import fp_exp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int BIAS  = 127,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             adj,
    input  logic [EXP_W-1:0] exp1,
    input  logic [EXP_W-1:0] exp2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             ovf,
    output logic             unf,
    output logic [TAG_W-1:0] tag_out,
    input  logic             clr_flags,
    output logic             sticky_ovf,
    output logic             sticky_unf
);

    localparam int IW = exp_int_w(EXP_W);
    localparam logic signed [IW-1:0] BIAS_S = IW'(BIAS);

    logic signed [IW-1:0] ext1, ext2, adj_s, r_comb;
    logic signed [IW-1:0] s1_r;
    logic [TAG_W-1:0]     s1_tag;
    logic                 s1_valid;
    logic                 s2_load, accept, out_hs;
    logic [EXP_W-1:0]     cls_exp;
    exp_flags_t           cls_flags;

    assign ext1  = $signed({2'b00, exp1});
    assign ext2  = $signed({2'b00, exp2});
    assign adj_s = $signed({{(IW-1){1'b0}}, adj});

`ifdef FP_EXP_DIV_EN
    exp_op_t op_sel;
    assign op_sel = exp_op_t'(op);

    always_comb begin
        r_comb = ext1 + ext2 - BIAS_S + adj_s;
        if (op_sel == EXP_DIV) begin
            r_comb = ext1 - ext2 + BIAS_S - adj_s;
        end
    end
`else
    // Without the divide path every request is computed as a multiply.
    logic unused_op;
    assign unused_op = op;
    assign r_comb    = ext1 + ext2 - BIAS_S + adj_s;
`endif

    // S2 frees up whenever it is empty or its result is being taken this cycle.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    fp_exp_classify #(
        .EXP_W (EXP_W)
    ) u_classify (
        .r       (s1_r),
        .exp_sat (cls_exp),
        .flags   (cls_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_r       <= '0;
            s1_tag     <= '0;
            out_valid  <= 1'b0;
            exp_out    <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            tag_out    <= '0;
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_r     <= r_comb;
                s1_tag   <= tag_in;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    exp_out <= cls_exp;
                    ovf     <= cls_flags.ovf;
                    unf     <= cls_flags.unf;
                    tag_out <= s1_tag;
                end
            end

            // A completing flagged result beats a simultaneous clear.
            if (out_hs && ovf) begin
                sticky_ovf <= 1'b1;
            end else if (clr_flags) begin
                sticky_ovf <= 1'b0;
            end
            if (out_hs && unf) begin
                sticky_unf <= 1'b1;
            end else if (clr_flags) begin
                sticky_unf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_exp_addsub_pipe.sv
// tb/tb_fp_exp_addsub_pipe.sv - directed table, corner sequences and random scoreboard for fp_exp_addsub_pipe
module tb_fp_exp_addsub_pipe;

    localparam int EXP_W = 8;
    localparam int BIAS  = 127;
    localparam int TAG_W = 4;
    localparam int MAXE  = 254;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, op, adj;
    logic [EXP_W-1:0] exp1, exp2, exp_out;
    logic [TAG_W-1:0] tag_in, tag_out;
    logic             out_valid, out_ready, ovf, unf;
    logic             clr_flags, sticky_ovf, sticky_unf;

    always #5 clk = ~clk;

    fp_exp_addsub_pipe #(
        .EXP_W (EXP_W),
        .BIAS  (BIAS),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .adj        (adj),
        .exp1       (exp1),
        .exp2       (exp2),
        .tag_in     (tag_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .ovf        (ovf),
        .unf        (unf),
        .tag_out    (tag_out),
        .clr_flags  (clr_flags),
        .sticky_ovf (sticky_ovf),
        .sticky_unf (sticky_unf)
    );

    typedef struct {
        bit op;
        bit adj;
        int e1;
        int e2;
        int tag;
        int x_exp;
        bit x_ovf;
        bit x_unf;
    } vec_t;

    typedef struct {
        int e;
        bit o;
        bit u;
        int tag;
    } res_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    res_t sb[$];
    res_t got[$];

    function automatic vec_t mk(bit o, bit a, int e1, int e2, int t, int xe, bit xo, bit xu);
        vec_t v;
        v.op = o; v.adj = a; v.e1 = e1; v.e2 = e2; v.tag = t;
        v.x_exp = xe; v.x_ovf = xo; v.x_unf = xu;
        return v;
    endfunction

    function automatic res_t model(bit op_i, bit adj_i, int e1, int e2, int t);
        res_t m;
        int   r;
        bit   d;
`ifdef FP_EXP_DIV_EN
        d = op_i;
`else
        d = 1'b0 & op_i;
`endif
        r     = d ? (e1 - e2 + BIAS - int'(adj_i)) : (e1 + e2 - BIAS + int'(adj_i));
        m.o   = (r > MAXE);
        m.u   = (r < 1);
        m.e   = m.o ? (1 << EXP_W) - 1 : (m.u ? 0 : r);
        m.tag = t;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic drive_op(input bit o, input bit a, input int e1, input int e2, input int t);
        in_valid = 1'b1;
        op       = o;
        adj      = a;
        exp1     = EXP_W'(e1);
        exp2     = EXP_W'(e2);
        tag_in   = TAG_W'(t);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    // One isolated operation: 2-cycle latency, result fields, then sticky state after handshake.
    task automatic run_vec(input vec_t v);
        clear_pulse();
        out_ready = 1'b1;
        drive_op(v.op, v.adj, v.e1, v.e2, v.tag);
        #1 check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("latency_1", out_valid, 0);
        @(posedge clk);
        #1 check("latency_2", out_valid, 1);
        check("exp_out", exp_out, v.x_exp);
        check("ovf", ovf, v.x_ovf);
        check("unf", unf, v.x_unf);
        check("tag_out", tag_out, v.tag);
        @(posedge clk);
        #1 check("sticky_ovf", sticky_ovf, v.x_ovf);
        check("sticky_unf", sticky_unf, v.x_unf);
        check("drained", out_valid, 0);
    endtask

    initial begin
        res_t e;
        bit   hs, acc, s_o, s_u;

        rst = 1'b1; in_valid = 1'b0; op = 1'b0; adj = 1'b0; exp1 = '0; exp2 = '0;
        tag_in = '0; out_ready = 1'b1; clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_exp_out", exp_out, 0);
        check("rst_tag_out", tag_out, 0);
        check("rst_flags", {ovf, unf, sticky_ovf, sticky_unf}, 0);

        vecs.push_back(mk(0, 0, 127, 127, 3, 127, 0, 0));
        vecs.push_back(mk(0, 0, 190, 191, 4, 254, 0, 0));
        vecs.push_back(mk(0, 1, 190, 191, 5, 255, 1, 0));
        vecs.push_back(mk(0, 0, 10, 20, 6, 0, 0, 1));
        vecs.push_back(mk(0, 1, 63, 64, 7, 1, 0, 0));
        vecs.push_back(mk(0, 0, 63, 64, 8, 0, 0, 1));
        vecs.push_back(mk(0, 1, 255, 255, 9, 255, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 10, 0, 0, 1));
`ifdef FP_EXP_DIV_EN
        vecs.push_back(mk(1, 0, 200, 73, 11, 254, 0, 0));
        vecs.push_back(mk(1, 1, 200, 73, 12, 253, 0, 0));
        vecs.push_back(mk(1, 0, 10, 200, 13, 0, 0, 1));
        vecs.push_back(mk(1, 0, 255, 0, 14, 255, 1, 0));
        vecs.push_back(mk(1, 1, 128, 128, 15, 126, 0, 0));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: two operations fill the pipe, the third waits.
        @(negedge clk);
        out_ready = 1'b0;
        drive_op(0, 0, 100, 100, 1);
        #1 check("bp_ready_1", in_ready, 1);
        @(negedge clk);
        drive_op(0, 0, 150, 120, 2);
        #1 check("bp_ready_2", in_ready, 1);
        @(negedge clk);
        drive_op(0, 0, 200, 60, 3);
        #1 check("bp_ready_full", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_exp_head", exp_out, 73);
        check("bp_tag_head", tag_out, 1);
        @(negedge clk);
        #1 check("bp_ready_still_full", in_ready, 0);
        check("bp_exp_held", exp_out, 73);
        check("bp_tag_held", tag_out, 1);
        out_ready = 1'b1;
        #1 check("bp_ready_release", in_ready, 1);
        got.delete();
        acc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (in_valid && in_ready) acc = 1'b1;
            if (out_valid && out_ready) begin
                e.e = exp_out; e.o = ovf; e.u = unf; e.tag = tag_out;
                got.push_back(e);
            end
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            #1;
        end
        check("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check("bp_order_tag", (k < got.size()) ? got[k].tag : -1, k + 1);
        end
        check("bp_exp_2", (got.size() > 1) ? got[1].e : -1, model(0, 0, 150, 120, 2).e);
        check("bp_exp_3", (got.size() > 2) ? got[2].e : -1, model(0, 0, 200, 60, 3).e);

        // Clear in the same cycle as an overflow handshake: the set must win.
        clear_pulse();
        out_ready = 1'b1;
        drive_op(0, 1, 190, 191, 2);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 check("clr_race_valid", out_valid, 1);
        clr_flags = 1'b1;
        @(posedge clk);
        #1 check("clr_race_sticky", sticky_ovf, 1);
        @(negedge clk);
        @(posedge clk);
        #1 check("clr_plain", sticky_ovf, 0);
        @(negedge clk);
        clr_flags = 1'b0;

        // Reset with two operations in flight.
        run_vec(mk(0, 0, 10, 20, 4, 0, 0, 1));
        @(negedge clk);
        out_ready = 1'b0;
        drive_op(0, 0, 120, 120, 5);
        @(negedge clk);
        drive_op(0, 0, 130, 130, 6);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 check("post_rst_valid", out_valid, 0);
        check("post_rst_sticky", {sticky_ovf, sticky_unf}, 0);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_exp", exp_out, 0);
        rst = 1'b0;
        run_vec(mk(0, 0, 127, 127, 9, 127, 0, 0));

        // Random stream against the scoreboard, including sticky tracking.
        clear_pulse();
        sb.delete();
        s_o = 1'b0;
        s_u = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c < 560) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
`ifdef FP_EXP_DIV_EN
                op        = 1'($urandom_range(0, 1));
`else
                op        = 1'b0;
`endif
                adj       = 1'($urandom_range(0, 1));
                exp1      = EXP_W'($urandom_range(0, 255));
                exp2      = EXP_W'($urandom_range(0, 255));
                tag_in    = TAG_W'($urandom_range(0, 15));
                clr_flags = ($urandom_range(0, 15) == 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                clr_flags = 1'b0;
            end
            #4;
            check("rnd_sticky_ovf", sticky_ovf, s_o);
            check("rnd_sticky_unf", sticky_unf, s_u);
            hs  = out_valid && out_ready;
            e.o = 1'b0;
            e.u = 1'b0;
            if (hs) begin
                if (sb.size() == 0) begin
                    check("rnd_spurious_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rnd_exp", exp_out, e.e);
                    check("rnd_flags", {ovf, unf}, {e.o, e.u});
                    check("rnd_tag", tag_out, e.tag);
                end
            end
            s_o = (hs && e.o) || (s_o && !clr_flags);
            s_u = (hs && e.u) || (s_u && !clr_flags);
            if (in_valid && in_ready) begin
                sb.push_back(model(op, adj, exp1, exp2, tag_in));
            end
        end
        check("rnd_all_out", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
